// File: rtl/bob_drain_pkg.sv
// Shared BOB geometry, drain FSM state encoding and the circular-index increment helper.
package bob_drain_pkg;

    localparam int BOB_ADDR_WIDTH = 6;
    localparam int BOB_COUNT      = 64;
    localparam int BOB_DATA_WIDTH = 65;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        LOOKUP,
        PRESENT
    } drain_state_e;

    // Next index in a window of 'count' entries; count need not be a power of two.
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned count);
        int unsigned nxt;
        nxt = ptr + 32'd1;
        return (nxt >= count) ? 32'd0 : nxt;
    endfunction

endpackage

// File: rtl/bob_drain_ptr.sv
// Wrapping index register: clears to 0, increments modulo COUNT; clear beats increment.
module bob_drain_ptr
    import bob_drain_pkg::*;
#(
    parameter int WIDTH = BOB_ADDR_WIDTH,
    parameter int COUNT = BOB_COUNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] ptr_o
);

    logic [WIDTH-1:0] ptr_q;
    logic [WIDTH-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = WIDTH'(wrap_inc(32'(ptr_q), COUNT));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/bob_drain.sv
// In-order BOB index allocator and retirement engine: grants head indices, polls the tail
// entry's ready bit, presents its payload on a valid/ready port and clears the ready bit.
module bob_drain
    import bob_drain_pkg::*;
#(
    parameter int ADDR_WIDTH = BOB_ADDR_WIDTH,
    parameter int ADDR_COUNT = BOB_COUNT,
    parameter int DATA_WIDTH = BOB_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  alloc_req,
    output logic                  alloc_gnt,
    output logic [ADDR_WIDTH-1:0] alloc_addr,
    output logic                  rd_clkEn,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_ready,
    output logic                  clr_wen,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  clr_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full
);

    localparam logic [ADDR_WIDTH:0]   CNT_FULL  = (ADDR_WIDTH+1)'(ADDR_COUNT);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] INIT_LAST = ADDR_WIDTH'(ADDR_COUNT - 1);
    localparam logic [ADDR_WIDTH-1:0] INIT_ONE  = ADDR_WIDTH'(1);

    drain_state_e          state_q;
    logic [ADDR_WIDTH-1:0] init_cnt_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_d;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [ADDR_WIDTH-1:0] out_addr_q;
    logic [ADDR_WIDTH-1:0] head;
    logic [ADDR_WIDTH-1:0] tail;
    logic [ADDR_WIDTH-1:0] tail_nxt;
    logic                  grant;
    logic                  retire;

    // Grant uses only the registered count, so a same-cycle retire never frees a slot early.
    assign grant    = alloc_req && !full && (state_q != INIT) && !flush;
    assign retire   = (state_q == PRESENT) && out_valid_q && out_ready;
    assign tail_nxt = ADDR_WIDTH'(wrap_inc(32'(tail), ADDR_COUNT));

    bob_drain_ptr #(
        .WIDTH (ADDR_WIDTH),
        .COUNT (ADDR_COUNT)
    ) u_head (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush),
        .inc_i (grant),
        .ptr_o (head)
    );

    bob_drain_ptr #(
        .WIDTH (ADDR_WIDTH),
        .COUNT (ADDR_COUNT)
    ) u_tail (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush),
        .inc_i (retire),
        .ptr_o (tail)
    );

    always_comb begin
        count_d = count_q;
        if (grant && !retire) begin
            count_d = count_q + CNT_ONE;
        end else if (retire && !grant) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Storage and ready-store control; a retiring PRESENT cycle chains straight into the next read.
    always_comb begin
        rd_clkEn = 1'b0;
        rd_addr  = tail;
        clr_wen  = 1'b0;
        clr_addr = tail;
        if (!rst) begin
            case (state_q)
                INIT: begin
                    clr_wen  = 1'b1;
                    clr_addr = init_cnt_q;
                end
                IDLE:    rd_clkEn = (count_q != '0);
                LOOKUP:  clr_wen  = rd_ready;
                PRESENT: begin
                    if (retire && (count_d != '0)) begin
                        rd_clkEn = 1'b1;
                        rd_addr  = tail_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
        end else if (flush) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            case (state_q)
                INIT: begin
                    init_cnt_q <= init_cnt_q + INIT_ONE;
                    if (init_cnt_q == INIT_LAST) begin
                        init_cnt_q <= '0;
                        state_q    <= IDLE;
                    end
                end
                IDLE: begin
                    if (count_q != '0) begin
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (rd_ready) begin
                        out_data_q  <= rd_data;
                        out_addr_q  <= tail;
                        out_valid_q <= 1'b1;
                        state_q     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (retire) begin
                        out_valid_q <= 1'b0;
                        state_q     <= (count_d != '0) ? LOOKUP : IDLE;
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign alloc_gnt  = grant;
    assign alloc_addr = head;
    assign clr_ready  = 1'b0;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_addr   = out_addr_q;
    assign count      = count_q;
    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_FULL);

endmodule

// File: doc/bob_drain.md
Name: bob_drain

Overview:
- In-order allocator and retirement engine for the BOB index space.
- Hands out BOB entry indices to producers, and tracks outstanding entries in a circular window.
- Drives the read side of the indexed BOB storage and ready store: polls the ready bit of the oldest entry, delivers its data to a consumer over a valid/ready handshake, and clears the entry's ready bit through the indirect ready write port.
- Sits between the BOB storage/ready RAMs and the retire consumer.

Parameters:
- ADDR_WIDTH, default bob_addr_width (6): BOB index width.
- ADDR_COUNT, default bob_count (64): number of BOB entries. Any value 2..2^ADDR_WIDTH; power of two not required.
- DATA_WIDTH, default 65: entry payload width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all outstanding entries
- alloc_req  in  1  producer requests one entry
- alloc_gnt  out  1  grant, same cycle as alloc_req
- alloc_addr  out  ADDR_WIDTH  index granted (equals head pointer)
- rd_clkEn  out  1  load storage read address register
- rd_addr  out  ADDR_WIDTH  storage read address
- rd_data  in  DATA_WIDTH  storage data at the registered read address
- rd_ready  in  1  ready bit at the registered read address
- clr_wen  out  1  indirect ready write enable
- clr_addr  out  ADDR_WIDTH  indirect ready write address
- clr_ready  out  1  indirect ready write data; constant 0
- out_valid  out  1  retired entry available
- out_ready  in  1  consumer accepts
- out_data  out  DATA_WIDTH  retired payload (registered)
- out_addr  out  ADDR_WIDTH  retired index (registered)
- count  out  ADDR_WIDTH+1  outstanding entries
- empty  out  1  count==0
- full  out  1  count==ADDR_COUNT

Behaviour:
- Reset values: head=0, tail=0, count=0, empty=1, full=0, out_valid=0, out_data=0, out_addr=0, init_cnt=0, state=INIT.
- In the reset cycle itself, clr_wen=0 and rd_clkEn=0.
- Pointers head and tail increment modulo ADDR_COUNT: ADDR_COUNT-1 wraps to 0.
- Allocation:
  - alloc_gnt = alloc_req & ~full & (state!=INIT) & ~flush. Combinational.
  - alloc_addr = head. On grant, head increments at the clock edge.
- count update:
  - +1 on grant only.
  - -1 on retire only.
  - Unchanged when grant and retire occur in the same cycle.
- State INIT:
  - clr_wen=1, clr_addr=init_cnt; init_cnt increments each cycle.
  - After the cycle with init_cnt==ADDR_COUNT-1, go to IDLE.
  - Takes exactly ADDR_COUNT cycles. No grants during INIT.
- State IDLE:
  - If count!=0: rd_clkEn=1, rd_addr=tail, go to LOOKUP.
  - Otherwise stay in IDLE with rd_clkEn=0.
- State LOOKUP (rd_data and rd_ready reflect tail):
  - If rd_ready=1: capture out_data<=rd_data and out_addr<=tail, set out_valid<=1. Drive clr_wen=1, clr_addr=tail. Go to PRESENT.
  - If rd_ready=0: stay in LOOKUP with rd_clkEn=0. The ready read is asynchronous on the held address, so a later producer write becomes visible one cycle after its write edge.
- State PRESENT:
  - out_valid=1; out_data and out_addr are held stable until acceptance.
  - Retire occurs on out_valid&out_ready: tail increments and out_valid<=0.
  - If (count after update)!=0: issue rd_clkEn=1, rd_addr=tail+1 (wrapped) in the same cycle and go to LOOKUP.
  - Otherwise go to IDLE.
  - Sustained throughput: one retire per 2 cycles.
- Minimum latency: alloc granted and data written in cycle 0 -> read issued in cycle 1 -> capture in cycle 2 -> out_valid in cycle 3.
- The ready clear at capture never conflicts with a producer write: the tail entry cannot be re-allocated until it retires.
- flush (any state), effective at the clock edge:
  - head=tail=count=0, out_valid=0, init_cnt=0, state=INIT.
  - A pending retire in the flush cycle is dropped; count is not decremented.
- rst takes priority over flush.
- Allocation is still blocked when full, even if a retire occurs in the same cycle. Grant depends only on the registered count.

Decomposition:
- Shared package holds BOB_ADDR_WIDTH, BOB_COUNT, BOB_DATA_WIDTH, and the state enum (INIT, IDLE, LOOKUP, PRESENT).
- One sub-module, bob_drain_ptr: wrapping pointer register with inc and clear inputs. Instantiated for head and tail.

Test Plan:
- Reset, then hold: clr_wen=1 for exactly 64 cycles with clr_addr 0..63 and clr_ready=0; alloc_gnt=0 throughout; IDLE afterwards.
- Alloc index 0, write ready+data 0x1_2345 in the same cycle, out_ready=1 -> out_valid in cycle 3 with out_addr=0, out_data=0x1_2345; clr_wen at addr 0 in cycle 2; count returns to 0.
- Allocate 0,1,2; mark ready in order 2,1,0 -> retires in order 0,1,2; no out_valid until entry 0 is ready.
- Allocate 64 entries -> full=1 and alloc_gnt=0 on the 65th request. Retire one -> grant the next cycle with alloc_addr=0 (wrap); head wraps 63->0.
- Hold out_ready=0 for 10 cycles in PRESENT -> out_data and out_addr stable. Simultaneous alloc+retire -> count unchanged.
- Assert flush with 5 outstanding entries and out_valid=1 -> next cycle out_valid=0, count=0, a 64-cycle INIT sweep, then first grant at alloc_addr=0.
